// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: a+b+cin computed LSB-first through one fulladder cell.
// Ports: clk, rst (sync, active-high), start, a, b, cin -> busy, done, sum, cout.
//
// fulladder
//   x, y, cin : input bits
//   s, cout   : sum bit and carry out
//
// serial_adder_ctrl
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high; aborts any operation in flight
//   start : request, honoured only in IDLE
//   a, b  : WIDTH-bit operands, captured when start is accepted
//   cin   : carry-in, captured when start is accepted
//   busy  : high while bits are being shifted through the adder
//   done  : one-cycle pulse when sum/cout take a new result
//   sum   : a+b+cin mod 2^WIDTH, held until the next result
//   cout  : carry out of the top bit, held with sum

module fulladder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic             c_q;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;

    fulladder u_fa (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (c_q),
        .cout (fa_cout),
        .s    (fa_s)
    );

    // New sum bit enters at the top so that after WIDTH shifts
    // bit 0 of the result sits at acc_sr[0]. Written this way
    // so WIDTH=1 needs no empty slice.
    always_comb begin
        acc_next            = acc_sr >> 1;
        acc_next[WIDTH-1]   = fa_s;
    end

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            acc_sr <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        c_q    <= cin;
                        cnt    <= '0;
                        acc_sr <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc_sr <= acc_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c_q    <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        // Result is published only once complete.
                        sum   <= acc_next;
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=4 and WIDTH=1.
// Each task drives one scenario and checks its own hand-computed results.

module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       cin4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int checks;
    int failures;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one WIDTH=4 op (accepted at the next posedge, E0), then
    // watch 10 negedges; index 0 is the negedge right after E0.
    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic c, output logic [3:0] s,
                        output logic co, output int nbusy,
                        output int ndone, output int done_at);
        @(negedge clk);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        a4 = 4'h5; b4 = 4'hA; cin4 = 1'b1;
        nbusy = 0; ndone = 0; done_at = -1; s = 'x; co = 1'bx;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy4) nbusy++;
            if (done4) begin
                ndone++;
                if (done_at < 0) done_at = i;
                s = sum4; co = cout4;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy4, done4, sum4, cout4} !== 7'b0) begin
            failures++;
            $display("FAIL reset_w4 got busy=%b done=%b sum=%h cout=%b expected all 0",
                     busy4, done4, sum4, cout4);
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'b0) begin
            failures++;
            $display("FAIL reset_w1 got busy=%b done=%b sum=%h cout=%b expected all 0",
                     busy1, done1, sum1, cout1);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        logic [3:0] s; logic co; int nb, nd, da;
        run4(4'h0, 4'h0, 1'b0, s, co, nb, nd, da);
        checks++;
        if (nb !== 4) begin
            failures++;
            $display("FAIL t1_busy_cycles got %0d expected 4", nb);
        end
        checks++;
        if (nd !== 1 || da !== 4) begin
            failures++;
            $display("FAIL t1_done got count=%0d at=%0d expected count=1 at=4", nd, da);
        end
        checks++;
        if ({co, s} !== 5'h00) begin
            failures++;
            $display("FAIL t1_result got cout=%b sum=%h expected cout=0 sum=0", co, s);
        end
    endtask

    task automatic test_add;
        logic [3:0] va [3] = '{4'hF, 4'h9, 4'hA};
        logic [3:0] vb [3] = '{4'h1, 4'h3, 4'h5};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [4:0] ve [3] = '{5'h10, 5'h0C, 5'h10};
        logic [3:0] s; logic co; int nb, nd, da;
        for (int k = 0; k < 3; k++) begin
            run4(va[k], vb[k], vc[k], s, co, nb, nd, da);
            checks++;
            if ({co, s} !== ve[k] || da !== 4) begin
                failures++;
                $display("FAIL t2_add%0d got cout=%b sum=%h at=%0d expected {cout,sum}=%h at=4",
                         k, co, s, da, ve[k]);
            end
        end
    endtask

    task automatic test_start_in_run;
        int nd;
        logic [4:0] res;
        @(negedge clk);
        a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        nd = 0; res = 'x;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a4 = 4'h7; b4 = 4'h7; cin4 = 1'b1; start4 = 1'b1;
            end else begin
                start4 = 1'b0;
            end
            if (done4) begin
                nd++;
                res = {cout4, sum4};
            end
        end
        checks++;
        if (nd !== 1) begin
            failures++;
            $display("FAIL t3_done_count got %0d expected 1", nd);
        end
        checks++;
        if (res !== 5'h05) begin
            failures++;
            $display("FAIL t3_result got %h expected 05", res);
        end
    endtask

    task automatic test_reset_mid;
        int nd;
        logic [3:0] s; logic co; int nb, da;
        @(negedge clk);
        a4 = 4'h6; b4 = 4'h7; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy4, done4, sum4, cout4} !== 7'b0) begin
            failures++;
            $display("FAIL t4_after_rst got busy=%b done=%b sum=%h cout=%b expected all 0",
                     busy4, done4, sum4, cout4);
        end
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done4 || busy4) nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL t4_no_done got %0d active cycles expected 0", nd);
        end
        run4(4'h6, 4'h7, 1'b0, s, co, nb, nd, da);
        checks++;
        if ({co, s} !== 5'h0D || nd !== 1) begin
            failures++;
            $display("FAIL t4_fresh got cout=%b sum=%h dones=%0d expected 0D dones=1",
                     co, s, nd);
        end
    endtask

    task automatic test_back_to_back;
        int t [3];
        int nd, unstable;
        logic [3:0] held;
        @(negedge clk);
        a4 = 4'h9; b4 = 4'h9; cin4 = 1'b0; start4 = 1'b1;
        nd = 0; unstable = 0; held = sum4;
        for (int i = 0; i < 40 && nd < 3; i++) begin
            @(negedge clk);
            if (done4) begin
                t[nd] = i;
                nd++;
                held = sum4;
                if (nd == 3) start4 = 1'b0;
            end else if (sum4 !== held) begin
                unstable++;
            end
        end
        start4 = 1'b0;
        checks++;
        if (nd !== 3) begin
            failures++;
            $display("FAIL t5_done_count got %0d expected 3", nd);
        end else begin
            checks++;
            if (t[1] - t[0] !== 6 || t[2] - t[1] !== 6) begin
                failures++;
                $display("FAIL t5_spacing got %0d,%0d expected 6,6",
                         t[1] - t[0], t[2] - t[1]);
            end
        end
        checks++;
        if (held !== 4'h2 || cout4 !== 1'b1 || unstable !== 0) begin
            failures++;
            $display("FAIL t5_result got sum=%h cout=%b unstable=%0d expected sum=2 cout=1 unstable=0",
                     held, cout4, unstable);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_width1;
        int da, nd, t0, t1;
        logic [1:0] res;
        logic [1:0] exp;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            a1 = k[2]; b1 = k[1]; cin1 = k[0]; start1 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            da = -1; res = 'x;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (done1 && da < 0) begin
                    da = i;
                    res = {cout1, sum1};
                end
            end
            exp = 2'(k[2]) + 2'(k[1]) + 2'(k[0]);
            checks++;
            if (res !== exp || da !== 1) begin
                failures++;
                $display("FAIL t6_combo%0d got %b at=%0d expected %b at=1",
                         k, res, da, exp);
            end
        end
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        nd = 0; t0 = 0; t1 = 0;
        for (int i = 0; i < 20 && nd < 2; i++) begin
            @(negedge clk);
            if (done1) begin
                if (nd == 0) t0 = i; else t1 = i;
                nd++;
            end
        end
        start1 = 1'b0;
        checks++;
        if (nd !== 2 || t1 - t0 !== 3) begin
            failures++;
            $display("FAIL t6_period got dones=%0d spacing=%0d expected 2 and 3",
                     nd, t1 - t0);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_zero();
        test_add();
        test_start_in_run();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
